// File: rtl/operand_mux_pipe_if.sv
// operand_mux_pipe_if: request/response bundle for operand_mux_pipe
//   in_valid/in_ready/in_data/sel   : upstream selection request handshake
//   out_valid/out_ready/out_data    : downstream result handshake
//   out_sel_err                     : head entry came from an out-of-range sel
//   clr_err/err_sticky/err_count    : error accounting control and status
//   master = requester/consumer side, slave = operand_mux_pipe side
interface operand_mux_pipe_if #(
    parameter int WIDTH = 64,
    parameter int N_IN  = 3
);
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      sel;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_sel_err;
    logic                  clr_err;
    logic                  err_sticky;
    logic [15:0]           err_count;
    modport master (
        output in_valid, in_data, sel, out_ready, clr_err,
        input  in_ready, out_valid, out_data, out_sel_err, err_sticky, err_count
    );
    modport slave (
        input  in_valid, in_data, sel, out_ready, clr_err,
        output in_ready, out_valid, out_data, out_sel_err, err_sticky, err_count
    );
endinterface

// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe: N_IN-way WIDTH-bit operand select into a 2-entry elastic output buffer
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : operand_mux_pipe_if.slave (request, result, error accounting)
module operand_mux_pipe #(
    parameter int WIDTH = 64,
    parameter int N_IN  = 3
) (
    input logic                clk,
    input logic                reset,
    operand_mux_pipe_if.slave  bus
);
    logic [WIDTH-1:0] mem_data [2];
    logic [1:0]       mem_err;
    logic             head, tail, run;
    logic [1:0]       count;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err, push, pop;
    // out-of-range selects match no input and fall through to zero
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_IN; k++)
            if (int'(bus.sel) == k) sel_data = bus.in_data[k*WIDTH +: WIDTH];
    end
    assign sel_err = int'(bus.sel) >= N_IN;
    // run keeps in_ready low through reset and until the first edge after it
    assign bus.in_ready    = run && count != 2'd2;
    assign bus.out_valid   = count != 2'd0;
    assign bus.out_data    = bus.out_valid ? mem_data[head] : '0;
    assign bus.out_sel_err = bus.out_valid && mem_err[head];
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    always_ff @(posedge clk)
        if (push) begin
            mem_data[tail] <= sel_data;
            mem_err[tail]  <= sel_err;
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            run   <= 1'b0;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            run <= 1'b1;
            if (push) tail <= ~tail;
            if (pop) head <= ~head;
            if (push && !pop) count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    // a clear coinciding with an erroneous accept records that accept
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.err_sticky <= 1'b0;
            bus.err_count  <= 16'd0;
        end else if (bus.clr_err) begin
            bus.err_sticky <= push && sel_err;
            bus.err_count  <= {15'd0, push && sel_err};
        end else if (push && sel_err) begin
            bus.err_sticky <= 1'b1;
            if (bus.err_count != 16'hFFFF) bus.err_count <= bus.err_count + 16'd1;
        end
endmodule

// File: tb/tb_operand_mux_pipe.sv
// tb_operand_mux_pipe: scoreboard bench for operand_mux_pipe (WIDTH=64, N_IN=3)
//   drives requests at negedge, expected entries queued on accept and
//   compared at the buffer head; error counters tracked by a small model
module tb_operand_mux_pipe;
    localparam int WIDTH = 64;
    localparam int N_IN  = 3;
    localparam int SEL_W = 2;
    typedef logic [WIDTH:0] entry_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    entry_t q[$];
    logic run_m = 1'b0;
    logic sticky_m = 1'b0;
    logic [15:0] cnt_m = 16'd0;
    logic [N_IN*WIDTH-1:0] abc;
    logic [N_IN*WIDTH-1:0] d3;
    operand_mux_pipe_if #(.WIDTH(WIDTH), .N_IN(N_IN)) bus ();
    operand_mux_pipe #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [N_IN*WIDTH-1:0] rnd();
        logic [N_IN*WIDTH-1:0] r;
        for (int i = 0; i < N_IN * 2; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction
    task automatic cycle(input logic v, input logic [SEL_W-1:0] s,
                         input logic [N_IN*WIDTH-1:0] d, input logic ordy, input logic clr);
        logic rdy_m, acc, pop_m, e;
        entry_t ent;
        @(negedge clk);
        bus.in_valid = v;
        bus.sel = s;
        bus.in_data = d;
        bus.out_ready = ordy;
        bus.clr_err = clr;
        #1;
        rdy_m = run_m && q.size() < 2;
        check("in_ready", 64'(bus.in_ready), 64'(rdy_m));
        check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", bus.out_data, q[0][WIDTH-1:0]);
            check("out_sel_err", 64'(bus.out_sel_err), 64'(q[0][WIDTH]));
        end
        acc = v && rdy_m;
        pop_m = q.size() != 0 && ordy;
        e = int'(s) >= N_IN;
        ent = {1'b1, {WIDTH{1'b0}}};
        if (!e) ent = {1'b0, d[int'(s)*WIDTH +: WIDTH]};
        @(posedge clk);
        if (pop_m) void'(q.pop_front());
        if (acc) q.push_back(ent);
        if (clr) begin
            sticky_m = acc && e;
            cnt_m = {15'd0, acc && e};
        end else if (acc && e) begin
            sticky_m = 1'b1;
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end
        run_m = 1'b1;
        #1;
        check("err_sticky", 64'(bus.err_sticky), 64'(sticky_m));
        check("err_count", 64'(bus.err_count), 64'(cnt_m));
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.sel = '0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.clr_err = 1'b0;
        abc = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_err_count", 64'(bus.err_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // in_ready rises only after the first edge past reset
        cycle(1'b0, 2'd0, abc, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, SEL_W'(i), abc, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 2'd0, abc, 1'b1, 1'b0);
        // out-of-range select, then a lone clear
        cycle(1'b1, 2'd3, abc, 1'b1, 1'b0);
        cycle(1'b0, 2'd0, abc, 1'b1, 1'b0);
        cycle(1'b0, 2'd0, abc, 1'b1, 1'b1);
        // stall: two absorbed, third held until the slot after the first pop
        d3 = rnd();
        cycle(1'b1, 2'd0, rnd(), 1'b0, 1'b0);
        cycle(1'b1, 2'd1, rnd(), 1'b0, 1'b0);
        cycle(1'b1, 2'd2, d3, 1'b0, 1'b0);
        cycle(1'b1, 2'd2, d3, 1'b1, 1'b0);
        cycle(1'b1, 2'd2, d3, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 2'd0, abc, 1'b1, 1'b0);
        // occupancy 1 with push and pop every cycle
        cycle(1'b1, 2'd1, rnd(), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, SEL_W'(i % 3), rnd(), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 2'd0, abc, 1'b1, 1'b0);
        // reset with two entries buffered
        cycle(1'b1, 2'd3, rnd(), 1'b0, 1'b0);
        cycle(1'b1, 2'd0, rnd(), 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_data", bus.out_data, 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_err_sticky", 64'(bus.err_sticky), 64'd0);
        q.delete();
        run_m = 1'b0;
        sticky_m = 1'b0;
        cnt_m = 16'd0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) cycle(1'b0, 2'd0, abc, 1'b1, 1'b0);
        // saturate the error counter, then clear together with an error
        for (int i = 0; i < 65536; i++) cycle(1'b1, 2'd3, abc, 1'b1, 1'b0);
        check("err_count_sat", 64'(bus.err_count), 64'hFFFF);
        cycle(1'b1, 2'd3, abc, 1'b1, 1'b1);
        check("err_count_clr_err", 64'(bus.err_count), 64'd1);
        repeat (2) cycle(1'b0, 2'd0, abc, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/operand_mux_pipe.md
# operand_mux_pipe

Parametrised N-input, WIDTH-bit operand selector with a registered, flow-controlled output. It replaces fixed three-way 64-bit forwarding/writeback selectors wherever the selected value must cross a pipeline boundary. Input-side backpressure is decoupled through a 2-entry elastic buffer. Out-of-range selects are flagged and counted, never propagated as unknowns.

## Interface
Parameters:
- WIDTH, 64, data width of each input and of the output
- N_IN, 3, number of selectable inputs (2..16)
- SEL_W, $clog2(N_IN) (min 1), select width; derived, not overridden

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents a selection request
- in_ready  out  1  block can accept a request this cycle
- in_data  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  binary index of the input to forward
- out_valid  out  1  out_data holds a valid entry
- out_ready  in  1  downstream consumes the entry this cycle
- out_data  out  WIDTH  selected value at buffer head
- out_sel_err  out  1  head entry was produced by an out-of-range sel
- clr_err  in  1  synchronous clear of err_sticky and err_count
- err_sticky  out  1  at least one out-of-range sel accepted since reset/clear
- err_count  out  16  saturating count of out-of-range accepts

## Operation
- Accept: in_valid && in_ready at a rising edge. Push {selected value, error bit} into the buffer tail.
- Selection: sel < N_IN gives in_data[sel*WIDTH +: WIDTH] with error bit 0. sel >= N_IN gives all-zero data with error bit 1. The output is never X.
- Buffer: 2-entry FIFO (head/tail pointers, 2-bit occupancy 0..2).
- in_ready = (occupancy < 2). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (occupancy != 0). out_data/out_sel_err come from the head. They hold stable while out_valid && !out_ready.
- Pop: out_valid && out_ready at a rising edge.
- Occupancy 1 with simultaneous push and pop: occupancy stays 1. The new entry becomes head after the edge.
- Occupancy 0 with a push: no bypass; the entry appears on the output the next cycle.
- Occupancy 2: no push is possible. A pop frees one slot and in_ready rises the following cycle.
- Error accounting: each accept with sel >= N_IN sets err_sticky and increments err_count, saturating at 16'hFFFF.
- clr_err alone zeroes err_sticky and err_count at the edge.
- clr_err coinciding with an erroneous accept: result is err_sticky=1, err_count=1.
- Error accounting is independent of downstream consumption.

## Timing
- Reset (async assert, effective immediately) sets occupancy=0, pointers=0, out_valid=0, out_data=0, out_sel_err=0, err_sticky=0, err_count=0.
- in_ready is 0 while reset is asserted and 1 from the first edge after deassertion.
- Reset mid-transfer discards all buffered entries without generating output.
- Latency: an entry accepted at edge t is visible on out_data after edge t when the buffer was empty. Otherwise it becomes visible after the edge that pops its predecessor.
- Throughput: 1 entry/cycle sustained when out_ready is held high.
- Stall: with out_ready low, at most 2 entries are absorbed, then in_ready drops.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Inputs in_data/sel are sampled only at the accepting edge.

## Test plan
- Reset then N_IN=3, WIDTH=64: in_data = {C,B,A} = {64'h3..3, 64'h2..2, 64'h1..1}, with sel=0,1,2 on consecutive cycles and out_ready=1. Required: out_data is 1..1, 2..2, 3..3 on cycles 1-3, out_valid continuous, out_sel_err=0.
- sel=2'b11 accepted once. Required: out_data=0, out_sel_err=1, err_sticky=1, err_count=1. Then clr_err pulse gives err_sticky=0, err_count=0.
- out_ready=0, drive 3 valid requests. Required: first two accepted, in_ready=0 afterwards, third held. Raise out_ready: outputs arrive in order, third accepted the cycle after the first pop.
- Occupancy 1 with simultaneous push/pop every cycle for 8 cycles. Required: occupancy stays 1, 8 outputs in order, no bubbles.
- Assert reset with 2 entries buffered. Required: out_valid=0 and out_data=0 immediately, no buffered entry emerges after release.
- Force err_count to saturation (65535 erroneous accepts, or N_IN=2 with sel width 1 skipped). Required: the next erroneous accept leaves err_count=16'hFFFF. A simultaneous clr_err + erroneous accept yields err_count=1.
